mult_accum: RTL
===============

# mult_accum

Downstream consumer of the 12-bit, 3-cycle multiplier stage in the float_arith/int path. It sums a window of unsigned 12-bit products plus a per-window bias, then saturates the total to 12 bits. It holds the result in an output register behind a valid/ready handshake. It back-pressures the operand source through `mult_ready_o`, because the multiplier itself cannot stall.

## Interface
- `MAX_TERMS`, default 16: maximum products per window; must be 2..256.
- `CNT_W`, default 5: term-counter width; must be at least clog2(MAX_TERMS+1).
- `clk_i` in 1: system clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `data_mult_i` in 12: unsigned product from the multiplier.
- `mult_valid_i` in 1: `data_mult_i` is valid this cycle.
- `mult_last_i` in 1: this beat closes the window; qualified by `mult_valid_i`.
- `bias_i` in 12: unsigned bias, sampled on the first beat of each window.
- `mult_ready_o` out 1: block can accept a beat this cycle. Combinational: `~sum_valid_o | sum_ready_i`.
- `sum_data_o` out 12: saturated window sum.
- `sum_valid_o` out 1: `sum_data_o` is valid.
- `sum_ready_i` in 1: downstream accepts `sum_data_o`.
- `term_cnt_o` out CNT_W: number of terms in the result currently presented.
- `overrun_o` out 1: sticky flag; a window hit MAX_TERMS without `mult_last_i`.
- `err_clr_i` in 1: synchronous clear of `overrun_o`.

## Operation
- Beat accepted = `mult_valid_i & mult_ready_o`. Beats with `mult_valid_i` high while `mult_ready_o` is low are dropped. The source must stall upstream of the multiplier early enough to avoid this.
- Internal accumulator `acc` is 12+CNT_W+1 bits wide, so it cannot wrap for MAX_TERMS terms plus bias.
- State machine:
  - IDLE (reset state): an accepted beat sets `acc <= bias_i + data_mult_i` and `cnt <= 1`. It goes to ACC, unless it is also the window close, in which case it stays in IDLE.
  - ACC: an accepted beat sets `acc <= acc + data_mult_i` and `cnt <= cnt + 1`.
- Window close happens on an accepted beat that has `mult_last_i = 1`, or that brings `cnt` to MAX_TERMS. On close:
  - `sum_data_o <= (acc_next > 4095) ? 4095 : acc_next[11:0]`.
  - `term_cnt_o <= cnt_next`.
  - `sum_valid_o <= 1`.
  - `acc` and `cnt` clear, and the state returns to IDLE.
- Forced close (`cnt` reaches MAX_TERMS with `mult_last_i = 0`) sets `overrun_o`. The following beats start a new window.
- A single-beat window (IDLE beat with `mult_last_i = 1`) gives `sat(bias + data)` with `term_cnt_o = 1`.
- Output register: `sum_valid_o` clears when `sum_ready_i = 1` and no close occurs in the same cycle. If a close and a handshake coincide, the new result replaces the old one and `sum_valid_o` stays 1.
- `overrun_o`: set has priority over `err_clr_i` in the same cycle. Otherwise `err_clr_i` clears it.

## Timing
- Asynchronous reset values: `sum_data_o = 0`, `sum_valid_o = 0`, `term_cnt_o = 0`, `overrun_o = 0`, `acc = 0`, `cnt = 0`, state IDLE.
- `mult_ready_o` resolves to 1 out of reset.
- Latency: a closing beat accepted at edge N gives `sum_valid_o = 1` after edge N, so the result is visible in cycle N+1.
- Throughput: one beat per cycle. Back-to-back single-beat windows sustain one result per cycle while `sum_ready_i = 1`.
- Backpressure: when `sum_valid_o = 1` and `sum_ready_i = 0`, `mult_ready_o = 0` and `acc`, `cnt` and state are frozen.
- `sum_data_o` and `term_cnt_o` are stable while `sum_valid_o = 1` and `sum_ready_i = 0`.
- Reset asserted mid-window discards the partial sum immediately. The first accepted beat after release is treated as a window start.

## Test plan
- **Basic window:** bias=0x010; beats 0x100, 0x200, 0x030 (last); `sum_ready_i = 1` → one cycle after the last beat, `sum_data_o = 0x340`, `term_cnt_o = 3`, `sum_valid_o` high for 1 cycle.
- **Saturation:** bias=0xFFF; beats 0xFF0 ×4, last on the 4th → `sum_data_o = 0xFFF`, `term_cnt_o = 4`, `overrun_o = 0`.
- **Backpressure:** close a window of 2 beats with `sum_ready_i = 0` for 5 cycles → `mult_ready_o = 0` and the result holds for those 5 cycles. A valid beat offered meanwhile is dropped and does not affect the next window. On release there is one transfer and `mult_ready_o` returns to 1.
- **Overrun:** MAX_TERMS=16; 18 beats of 0x001, bias 0, `mult_last_i` only on beat 18 → first result 0x010 with `term_cnt_o = 16` and `overrun_o = 1`; second result 0x002 with `term_cnt_o = 2`. `err_clr_i` pulse clears `overrun_o`.
- **Back-to-back:** single-beat windows every cycle (data = k, bias = 1) → results k+1 on consecutive cycles with no gaps. A close coinciding with a handshake keeps `sum_valid_o` continuously high.
- **Reset mid-window:** 2 beats accepted, then `rst_n_i` low asynchronously between edges → all outputs 0 immediately. After release, a window of one beat 0x005 with bias 0 gives 0x005.

Source files
------------

// File: rtl/mult_accum.sv
// Window accumulator for unsigned 12-bit products: sums a window of beats plus a bias,
// saturates to 12 bits and presents the result behind a valid/ready output register.
module mult_accum #(
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [11:0]      data_mult_i,
  input  logic             mult_valid_i,
  input  logic             mult_last_i,
  input  logic [11:0]      bias_i,
  output logic             mult_ready_o,
  output logic [11:0]      sum_data_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic [CNT_W-1:0] term_cnt_o,
  output logic             overrun_o,
  input  logic             err_clr_i
);

  localparam int ACC_W = 12 + CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_next;
  logic [11:0]        sum_data_q, sum_data_d;
  logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
  logic               sum_valid_q, sum_valid_d;
  logic               overrun_q, overrun_d;
  logic               accept, hit_max, close_win;

  // The multiplier cannot stall, so readiness depends only on the output slot.
  assign mult_ready_o = ~sum_valid_q | sum_ready_i;
  assign accept       = mult_valid_i & mult_ready_o;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_data_d  = sum_data_q;
    term_cnt_d  = term_cnt_q;
    sum_valid_d = sum_valid_q;
    overrun_d   = overrun_q;

    // First beat of a window folds in the bias; acc_q is ignored in IDLE.
    if (state_q == IDLE) begin
      acc_next = ACC_W'(bias_i) + ACC_W'(data_mult_i);
      cnt_next = CNT_W'(1);
    end else begin
      acc_next = acc_q + ACC_W'(data_mult_i);
      cnt_next = cnt_q + CNT_W'(1);
    end
    hit_max   = (cnt_next == MAX_CNT);
    close_win = accept & (mult_last_i | hit_max);

    if (accept) begin
      if (close_win) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = acc_next;
        cnt_d   = cnt_next;
        state_d = ACC;
      end
    end

    if (close_win) begin
      sum_data_d  = (|acc_next[ACC_W-1:12]) ? 12'hFFF : acc_next[11:0];
      term_cnt_d  = cnt_next;
      sum_valid_d = 1'b1;
    end else if (sum_ready_i) begin
      sum_valid_d = 1'b0;
    end

    if (accept & hit_max & ~mult_last_i) begin
      overrun_d = 1'b1;
    end else if (err_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_data_q  <= '0;
      term_cnt_q  <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_data_q  <= sum_data_d;
      term_cnt_q  <= term_cnt_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sum_data_o  = sum_data_q;
  assign term_cnt_o  = term_cnt_q;
  assign sum_valid_o = sum_valid_q;
  assign overrun_o   = overrun_q;

endmodule
